// File: rtl/gr_wb_sched.sv
// gr_wb_sched: write-back scheduler and load scoreboard for the 16 x 32-bit
// register file. Arbitrates the single write port between the execute pipe
// and the load unit, registers the winning write, and stalls issue of any
// instruction that touches a register with an outstanding load.
//
// Handshake (ex_* and ld_*): a transfer happens in a cycle where valid and
// ready are both high. The requester holds valid, rd and data stable until
// accepted. ready may depend combinationally on valid.
module gr_wb_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        iss_valid_i,
  input  logic [3:0]  iss_rs1_i,
  input  logic [3:0]  iss_rs2_i,
  input  logic [3:0]  iss_rd_i,
  input  logic        iss_is_load_i,
  output logic        iss_stall_o,
  input  logic        ex_valid_i,
  input  logic [3:0]  ex_rd_i,
  input  logic [31:0] ex_data_i,
  output logic        ex_ready_o,
  input  logic        ld_valid_i,
  input  logic [3:0]  ld_rd_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_ready_o,
  output logic        wb_en_o,
  output logic [3:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic [15:0] dbg_pending_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] pending_q, pending_d;
  logic        wb_en_q, wb_en_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_is_ld_q, wb_is_ld_d;

  logic starve;
  logic ex_grant;
  logic ld_grant;
  logic iss_accept;
  logic [15:0] set_mask;
  logic [15:0] clr_mask;

  // Arbitration: loads win by default; execute wins once it has been starved
  // for STARVE_LIMIT consecutive cycles. Stall on RAW (rs1/rs2) and WAW (rd).
  always_comb begin
    starve      = (cnt_q == LIMIT);
    ex_ready_o  = !ld_valid_i | starve;
    ld_ready_o  = !(ex_valid_i & starve);
    ex_grant    = ex_valid_i & ex_ready_o;
    ld_grant    = ld_valid_i & !ex_grant;
    iss_stall_o = iss_valid_i &
                  ((pending_q[iss_rs1_i] & (iss_rs1_i != 4'd0)) |
                   (pending_q[iss_rs2_i] & (iss_rs2_i != 4'd0)) |
                   (pending_q[iss_rd_i]  & (iss_rd_i  != 4'd0)));
    iss_accept  = iss_valid_i & !iss_stall_o;
  end

  // Next state: starvation counter, output stage and load scoreboard.
  always_comb begin
    cnt_d      = cnt_q;
    wb_en_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_is_ld_d = wb_is_ld_q;
    set_mask   = 16'd0;
    clr_mask   = 16'd0;

    if (ex_grant) begin
      cnt_d = 4'd0;
    end else if (ex_valid_i && !ex_ready_o && cnt_q != LIMIT) begin
      cnt_d = cnt_q + 4'd1;
    end

    if (ex_grant) begin
      wb_en_d    = (ex_rd_i != 4'd0);
      wb_rd_d    = ex_rd_i;
      wb_data_d  = ex_data_i;
      wb_is_ld_d = 1'b0;
    end else if (ld_grant) begin
      wb_en_d    = (ld_rd_i != 4'd0);
      wb_rd_d    = ld_rd_i;
      wb_data_d  = ld_data_i;
      wb_is_ld_d = 1'b1;
    end

    // A load write sitting in the output stage lands in the file at this
    // edge, so its pending bit may drop now. Set is applied last so it wins.
    if (wb_en_q && wb_is_ld_q) clr_mask[wb_rd_q] = 1'b1;
    if (iss_accept && iss_is_load_i && iss_rd_i != 4'd0) set_mask[iss_rd_i] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q      <= 4'd0;
      pending_q  <= 16'd0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= 4'd0;
      wb_data_q  <= 32'd0;
      wb_is_ld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_is_ld_q <= wb_is_ld_d;
    end
  end

  assign wb_en_o       = wb_en_q;
  assign wb_rd_o       = wb_rd_q;
  assign wb_data_o     = wb_data_q;
  assign dbg_pending_o = pending_q;

endmodule

// File: tb/tb_gr_wb_sched.sv
// Directed bench for gr_wb_sched with an expected-write queue.
module tb_gr_wb_sched;

  logic        clk;
  logic        reset;
  logic        iss_valid;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_is_load;
  logic        iss_stall;
  logic        ex_valid;
  logic [3:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ex_ready;
  logic        ld_valid;
  logic [3:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [15:0] pending;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  logic [35:0] exp_q[$];

  gr_wb_sched #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .iss_valid_i(iss_valid), .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2),
    .iss_rd_i(iss_rd), .iss_is_load_i(iss_is_load), .iss_stall_o(iss_stall),
    .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_data_i(ex_data), .ex_ready_o(ex_ready),
    .ld_valid_i(ld_valid), .ld_rd_i(ld_rd), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
    .wb_en_o(wb_en), .wb_rd_o(wb_rd), .wb_data_o(wb_data), .dbg_pending_o(pending)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks: one accepted transfer per call; expectation pushed on accept.
  task automatic send_ex(input logic [3:0] rd, input logic [31:0] data);
    ex_valid = 1'b1; ex_rd = rd; ex_data = data;
    #1;
    chk("ex_ready_single", 32'(ex_ready), 32'd1);
    if (rd != 4'd0) exp_q.push_back({rd, data});
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic send_ld(input logic [3:0] rd, input logic [31:0] data);
    ld_valid = 1'b1; ld_rd = rd; ld_data = data;
    #1;
    chk("ld_ready_single", 32'(ld_ready), 32'd1);
    if (rd != 4'd0) exp_q.push_back({rd, data});
    tick();
    ld_valid = 1'b0;
  endtask

  // Scoreboard monitor: every write-back must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en && wb_en) begin
      if (exp_q.size() == 0) begin
        chk("wb_spurious", 32'(wb_rd), 32'hFFFF_FFFF);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e[35:32]));
        chk("wb_data", wb_data, e[31:0]);
      end
    end
  end

  initial begin
    reset = 1'b0;
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_is_load = 0;
    ex_valid = 0; ex_rd = 0; ex_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    #2 reset = 1'b1;

    // Reset & idle: cleared state and combinational outputs under reset
    tick(); tick();
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    iss_valid = 1; iss_rs1 = 5; iss_rs2 = 6; iss_rd = 7; iss_is_load = 1;
    ld_valid = 1;
    #1;
    chk("rst_iss_stall", 32'(iss_stall), 32'd0);
    chk("rst_ex_ready_ld", 32'(ex_ready), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    ld_valid = 0; ex_valid = 1;
    #1;
    chk("rst_ex_ready_idle", 32'(ex_ready), 32'd1);
    chk("rst_ld_ready_ex", 32'(ld_ready), 32'd1);
    ex_valid = 0; iss_valid = 0; iss_is_load = 0;
    #1 reset = 1'b0;
    tick();

    // Build some state, then reset mid-cycle while wb_en=1
    iss_valid = 1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 9; iss_is_load = 1;
    #1;
    chk("ld9_issue_stall", 32'(iss_stall), 32'd0);
    tick();
    iss_valid = 0; iss_is_load = 0;
    chk("ld9_pending", 32'(pending), 32'h0200);
    ex_valid = 1; ex_rd = 7; ex_data = 32'h0000_00AA;
    tick();
    ex_valid = 0;
    chk("pre_rst_wb_en", 32'(wb_en), 32'd1);
    chk("pre_rst_wb_rd", 32'(wb_rd), 32'd7);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wb_en", 32'(wb_en), 32'd0);
    chk("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    #2 reset = 1'b0;
    tick();
    mon_en = 1'b1;

    // Single writes
    send_ex(4'd3, 32'h1234_5678);
    chk("single_wb_en", 32'(wb_en), 32'd1);
    tick();
    chk("single_wb_en_off", 32'(wb_en), 32'd0);
    send_ex(4'd0, 32'hCAFE_0000);
    chk("x0_ex_wb_en", 32'(wb_en), 32'd0);

    // Conflict & starvation: loads win 4 cycles, then execute
    ld_valid = 1; ld_rd = 4; ex_valid = 1; ex_rd = 6; ex_data = 32'h6666_0006;
    for (int i = 0; i < 4; i++) begin
      ld_data = 32'h0000_0100 + 32'(i);
      #1;
      chk("starve_ld_ready", 32'(ld_ready), 32'd1);
      chk("starve_ex_ready", 32'(ex_ready), 32'd0);
      exp_q.push_back({4'd4, ld_data});
      tick();
    end
    ld_data = 32'h0000_0200;
    #1;
    chk("starve5_ex_ready", 32'(ex_ready), 32'd1);
    chk("starve5_ld_ready", 32'(ld_ready), 32'd0);
    exp_q.push_back({4'd6, ex_data});
    tick();
    ex_rd = 8; ex_data = 32'h8888_0008;
    #1;
    chk("resume_ex_ready", 32'(ex_ready), 32'd0);
    chk("resume_ld_ready", 32'(ld_ready), 32'd1);
    exp_q.push_back({4'd4, ld_data});
    tick();
    ld_valid = 0;
    #1;
    chk("resume_ex_alone", 32'(ex_ready), 32'd1);
    exp_q.push_back({4'd8, ex_data});
    tick();
    ex_valid = 0;

    // Scoreboard RAW / WAW
    iss_valid = 1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 5; iss_is_load = 1;
    #1;
    chk("ld5_issue_stall", 32'(iss_stall), 32'd0);
    tick();
    chk("ld5_pending", 32'(pending), 32'h0020);
    iss_rs1 = 5; iss_rs2 = 1; iss_rd = 2; iss_is_load = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("raw_rs1_stall", 32'(iss_stall), 32'd1);
      tick();
    end
    iss_rs1 = 1; iss_rs2 = 5;
    #1;
    chk("raw_rs2_stall", 32'(iss_stall), 32'd1);
    iss_rs1 = 0; iss_rs2 = 0; iss_rd = 5; iss_is_load = 1;
    #1;
    chk("waw_load_stall", 32'(iss_stall), 32'd1);
    iss_valid = 0;
    #1;
    chk("no_valid_stall", 32'(iss_stall), 32'd0);
    iss_valid = 1; iss_rs1 = 5; iss_rs2 = 1; iss_rd = 2; iss_is_load = 0;
    ld_valid = 1; ld_rd = 5; ld_data = 32'hDEAD_BEEF;
    #1;
    chk("raw_stall_cycN", 32'(iss_stall), 32'd1);
    chk("ld5_ready", 32'(ld_ready), 32'd1);
    exp_q.push_back({4'd5, ld_data});
    tick();
    ld_valid = 0;
    #1;
    chk("raw_stall_cycN1", 32'(iss_stall), 32'd1);
    tick();
    chk("raw_stall_cycN2", 32'(iss_stall), 32'd0);
    chk("ld5_cleared", 32'(pending), 32'h0000);
    tick();
    iss_valid = 0;

    // x0 handling
    iss_valid = 1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_is_load = 1;
    #1;
    chk("x0_ld_issue", 32'(iss_stall), 32'd0);
    tick();
    chk("x0_no_pending", 32'(pending), 32'h0000);
    iss_is_load = 0; iss_rs1 = 0; iss_rd = 3;
    #1;
    chk("x0_rs1_stall", 32'(iss_stall), 32'd0);
    tick();
    iss_valid = 0;
    send_ld(4'd0, 32'h0BAD_0000);
    chk("x0_ld_wb_en", 32'(wb_en), 32'd0);

    // Back-to-back alternating ex/ld, 8 cycles
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = $urandom;
      if (i % 2 == 0) begin
        ld_valid = 0; ex_valid = 1; ex_rd = 4'(i + 1); ex_data = d;
        #1;
        chk("b2b_ex_ready", 32'(ex_ready), 32'd1);
      end else begin
        ex_valid = 0; ld_valid = 1; ld_rd = 4'(i + 1); ld_data = d;
        #1;
        chk("b2b_ld_ready", 32'(ld_ready), 32'd1);
      end
      exp_q.push_back({4'(i + 1), d});
      tick();
      chk("b2b_wb_en", 32'(wb_en), 32'd1);
    end
    ex_valid = 0; ld_valid = 0;
    tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gr_wb_sched.md
Name: gr_wb_sched

Overview:
- Write-back scheduler and load scoreboard for the 16 x 32-bit general register file (single write port, two read ports; x0 reads as zero).
- Shares the one write port between the execute pipe (single-cycle ALU results) and the load unit (variable-latency memory returns).
- Tracks registers with an outstanding load and stalls any issue that reads or overwrites them.
- Sits between decode/issue, the execute pipe, the load unit and the register-file write port.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles execute may be denied before it takes priority over loads (1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- iss_valid  in  1  decode presents an instruction.
- iss_rs1  in  4  source register 1.
- iss_rs2  in  4  source register 2.
- iss_rd  in  4  destination register.
- iss_is_load  in  1  instruction is a load.
- iss_stall  out  1  instruction must not issue this cycle.
- ex_valid  in  1  execute result available.
- ex_rd  in  4  execute destination.
- ex_data  in  32  execute result.
- ex_ready  out  1  execute result accepted this cycle.
- ld_valid  in  1  load data available.
- ld_rd  in  4  load destination.
- ld_data  in  32  load data.
- ld_ready  out  1  load data accepted this cycle.
- wb_en  out  1  register-file write enable.
- wb_rd  out  4  register-file write index.
- wb_data  out  32  register-file write data.

Behaviour:
- Reset (async, immediate) clears:
  - wb_en, wb_rd, wb_data to 0;
  - the pending[15:0] scoreboard;
  - the starvation counter.
- Combinational outputs during reset are computed from the cleared state:
  - iss_stall=0;
  - ex_ready=!ld_valid;
  - ld_ready=1.
- Handshake: a transfer occurs in a cycle with valid & ready. Requesters hold valid, rd and data stable until accepted. ready may depend combinationally on valid.
- Arbitration:
  - starve = (cnt == STARVE_LIMIT).
  - ex_grant = ex_valid & (!ld_valid | starve).
  - ld_grant = ld_valid & !ex_grant.
  - ex_ready = !ld_valid | starve.
  - ld_ready = !(ex_valid & starve).
  - Only one transfer per cycle.
- Starvation counter:
  - increments when ex_valid & !ex_ready, saturating at STARVE_LIMIT;
  - clears on any ex transfer;
  - holds otherwise.
- Output stage is registered:
  - A transfer accepted at edge N drives wb_en=(rd!=0), wb_rd and wb_data during cycle N+1. The register file writes at edge N+1.
  - With no transfer, wb_en=0 next cycle; wb_rd and wb_data hold.
  - Writes to x0 are accepted (ready as normal) but never assert wb_en.
- Scoreboard:
  - Set: issue accepted (iss_valid & !iss_stall) with iss_is_load & iss_rd!=0 sets pending[iss_rd] at that edge.
  - Clear: pending[r] clears at the edge where a load write to r is in the output stage (wb_en=1 and the stage holds a load). The bit therefore stays set until the data is in the file.
  - Stall: iss_stall = iss_valid & (pending[rs1]&rs1!=0 | pending[rs2]&rs2!=0 | pending[rd]&rd!=0).
    - Covers RAW on both sources and WAW on rd, for every instruction type.
  - iss_stall=0 whenever iss_valid=0.
- Simultaneous set and clear of the same index cannot occur, because issue to a pending rd stalls. If it occurs anyway, set wins.
- An execute write to a register with pending=1 cannot occur given the stall rule. No checking is required; the write proceeds.
- Loads to a register with no pending bit are written normally and leave the scoreboard unchanged.
- Reset mid-operation drops all in-flight writes and pending bits. Requesters are reset by the same signal.

Test Plan:
- Reset & idle:
  - Stimulus: assert reset mid-cycle with wb_en=1.
  - Required: wb_en, wb_rd and wb_data go to 0 immediately; pending=0; iss_stall=0 for any input.
- Single writes:
  - Stimulus: ex_valid, ex_rd=3, ex_data=0x12345678 for one cycle.
  - Required: ex_ready=1; next cycle wb_en=1, wb_rd=3, wb_data=0x12345678; following cycle wb_en=0.
  - Stimulus: ex_rd=0.
  - Required: accepted, wb_en stays 0.
- Conflict & starvation:
  - Stimulus: ld_valid and ex_valid both held high with STARVE_LIMIT=4.
  - Required: loads are accepted for 4 cycles; in cycle 5 ex_ready=1 and ld_ready=0; the counter returns to 0 and loads resume.
- Scoreboard RAW/WAW:
  - Stimulus: issue a load to rd=5, then issue add rs1=5.
  - Required: iss_stall=1 until the load return to x5 is accepted at edge N; stall is still 1 in cycle N+1; stall drops in cycle N+2.
  - Stimulus: a second load to rd=5 issued while the first is pending.
  - Required: stalls.
- x0 handling:
  - Stimulus: load to rd=0.
  - Required: no pending bit is set; a following instruction with rs1=0 never stalls; the return is accepted with wb_en=0.
- Back-to-back throughput:
  - Stimulus: alternate ex and ld transfers on 8 consecutive cycles with no conflict.
  - Required: 8 consecutive cycles of wb_en=1 with matching rd and data, in acceptance order.
